// File: rtl/cpu_pkg.sv
// Shared CPU constants: R-type funct codes for the multiply/divide unit and its
// sequencer states, also used by the main control decoder.
package cpu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FN_MFHI) || (f == FN_MTHI) || (f == FN_MFLO) || (f == FN_MTLO) ||
               (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    // MULT/MULTU/DIV/DIVU share 0110xx: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic is_calc_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
interface muldiv_seq_if;

    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, funct, a, b, cancel,
        input  busy, stall, done, mf_data, hi, lo
    );

    modport slave (
        input  op_valid, funct, a, b, cancel,
        output busy, stall, done, mf_data, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide loop
// on the 64-bit working register {acc,mplier} / {rem,quot}.
module muldiv_step
    import cpu_pkg::*;
(
    input  md_mode_e    mode,
    input  logic [63:0] work_in,
    input  logic [31:0] operand,
    output logic [63:0] work_out
);

    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [31:0] div_diff;

    // When the trial fits, trial - divisor is below the divisor, so 32 bits suffice.
    // With a zero divisor every step subtracts nothing: quotient all ones, remainder = dividend.
    always_comb begin
        mul_sum   = {1'b0, work_in[63:32]} + (work_in[0] ? {1'b0, operand} : 33'd0);
        div_trial = work_in[63:31];
        div_diff  = div_trial[31:0] - operand;
        work_out  = {mul_sum, work_in[31:1]};
        if (mode == MODE_DIV) begin
            if (div_trial >= {1'b0, operand}) begin
                work_out = {div_diff, work_in[30:0], 1'b1};
            end else begin
                work_out = {div_trial[31:0], work_in[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: 32 CALC cycles plus one FIX
// cycle per MULT/DIV, stalling further md instructions while it runs.
module muldiv_seq
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  md
);

    md_state_e   state_q, state_d;
    md_mode_e    mode_q, mode_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] operand_q, operand_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic [63:0] product;
    logic [63:0] step_out;

    muldiv_step u_step (
        .mode     (mode_q),
        .work_in  (work_q),
        .operand  (operand_q),
        .work_out (step_out)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        operand_d = operand_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed = ~md.funct[0];
        a_neg     = is_signed & md.a[31];
        b_neg     = is_signed & md.b[31];
        a_mag     = a_neg ? -md.a : md.a;
        b_mag     = b_neg ? -md.b : md.b;
        div_zero  = md.funct[1] & (md.b == 32'd0);
        product   = neg_q ? -work_q : work_q;

        case (state_q)
            MD_IDLE: begin
                if (md.op_valid && !md.cancel) begin
                    if (is_calc_funct(md.funct)) begin
                        // Divide by zero runs the raw dividend unsigned so the loop yields HI=a, LO=all ones.
                        mode_d    = md.funct[1] ? MODE_DIV : MODE_MUL;
                        work_d    = {32'd0, div_zero ? md.a : a_mag};
                        operand_d = b_mag;
                        neg_d     = ~div_zero & (a_neg ^ b_neg);
                        neg_rem_d = ~div_zero & a_neg;
                        cnt_d     = 5'd0;
                        state_d   = MD_CALC;
                    end else if (md.funct == FN_MTHI) begin
                        hi_d = md.a;
                    end else if (md.funct == FN_MTLO) begin
                        lo_d = md.a;
                    end
                end
            end
            MD_CALC: begin
                work_d = step_out;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (mode_q == MODE_MUL) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end else begin
                    hi_d = neg_rem_q ? -work_q[63:32] : work_q[63:32];
                    lo_d = neg_q ? -work_q[31:0] : work_q[31:0];
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        // A flush kills whatever is in flight, including a same-cycle accept or HI/LO write.
        if (md.cancel) begin
            state_d = MD_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            mode_q    <= MODE_MUL;
            cnt_q     <= 5'd0;
            work_q    <= 64'd0;
            operand_q <= 32'd0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            operand_q <= operand_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign md.busy    = (state_q != MD_IDLE);
    assign md.stall   = md.busy & md.op_valid & is_md_funct(md.funct);
    assign md.done    = done_q;
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;
    assign md.mf_data = !md.op_valid           ? 32'd0 :
                        (md.funct == FN_MFHI)  ? hi_q  :
                        (md.funct == FN_MFLO)  ? lo_q  : 32'd0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: an arithmetic model of HI/LO and latency checked
// every cycle, plus hand-computed results for each directed scenario.
module tb_muldiv_seq;
    import cpu_pkg::*;

    localparam logic [5:0] FN_ADD = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_if md_if ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    // Model state: cycles left until the pending result lands, and architectural HI/LO.
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_pend_hi = '0;
    logic [31:0] m_pend_lo = '0;
    logic        m_done = 1'b0;

    function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] x,
                                                 input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        model_result = '0;
        if ((f == FN_DIV || f == FN_DIVU) && y == 32'd0) begin
            model_result = {x, 32'hFFFFFFFF};
        end else if (f == FN_MULT) begin
            model_result = 64'(sx * sy);
        end else if (f == FN_MULTU) begin
            model_result = ux * uy;
        end else if (f == FN_DIV) begin
            q = sx / sy;
            r = sx % sy;
            model_result = {r[31:0], q[31:0]};
        end else if (f == FN_DIVU) begin
            model_result = {32'(ux % uy), 32'(ux / uy)};
        end
    endfunction

    function automatic logic model_is_md(input logic [5:0] f);
        return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (md_if.cancel) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = m_pend_hi;
                    m_lo   = m_pend_lo;
                    m_done = 1'b1;
                end
            end else if (md_if.op_valid) begin
                case (md_if.funct)
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        {m_pend_hi, m_pend_lo} = model_result(md_if.funct, md_if.a, md_if.b);
                        m_left = 33;
                    end
                    FN_MTHI: m_hi = md_if.a;
                    FN_MTLO: m_lo = md_if.a;
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin : compare
        logic        exp_busy;
        logic        exp_stall;
        logic [31:0] exp_mf;
        exp_busy  = (m_left != 0);
        exp_stall = exp_busy && md_if.op_valid && model_is_md(md_if.funct);
        exp_mf    = '0;
        if (md_if.op_valid && md_if.funct == FN_MFHI) exp_mf = m_hi;
        if (md_if.op_valid && md_if.funct == FN_MFLO) exp_mf = m_lo;
        checkOutput("cyc_busy", md_if.busy, exp_busy);
        checkOutput("cyc_stall", md_if.stall, exp_stall);
        checkOutput("cyc_done", md_if.done, m_done);
        checkOutput("cyc_hi", md_if.hi, m_hi);
        checkOutput("cyc_lo", md_if.lo, m_lo);
        checkOutput("cyc_mf_data", md_if.mf_data, exp_mf);
    end

    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] x,
                                 input logic [31:0] y, input logic c);
        @(posedge clk);
        #1;
        md_if.op_valid = v;
        md_if.funct    = f;
        md_if.a        = x;
        md_if.b        = y;
        md_if.cancel   = c;
    endtask

    task automatic waitDone(input string name, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (md_if.done) return;
            if (md_if.busy) busy_cycles++;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: done not seen, got %0d busy cycles, required done within 60", name,
                 busy_cycles);
    endtask

    task automatic runCheck(input string name, input logic [5:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int cyc;
        applyStimulus(1'b1, f, x, y, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        waitDone(name, cyc);
        checkOutput({name, "_busy_cycles"}, cyc, 32'd33);
        checkOutput({name, "_done"}, md_if.done, 32'd1);
        checkOutput({name, "_hi"}, md_if.hi, exp_hi);
        checkOutput({name, "_lo"}, md_if.lo, exp_lo);
        checkOutput({name, "_model_hi"}, m_hi, exp_hi);
        checkOutput({name, "_model_lo"}, m_lo, exp_lo);
    endtask

    initial begin
        int cyc;
        int stall_cycles;
        int done_pulses;
        logic found;

        md_if.op_valid = 1'b0;
        md_if.funct    = '0;
        md_if.a        = '0;
        md_if.b        = '0;
        md_if.cancel   = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", md_if.hi, 32'd0);
        checkOutput("reset_lo", md_if.lo, 32'd0);
        checkOutput("reset_busy", md_if.busy, 32'd0);
        checkOutput("reset_done", md_if.done, 32'd0);

        runCheck("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runCheck("mult_neg", FN_MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runCheck("div_neg", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runCheck("divu_zero", FN_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        runCheck("div_zero_neg", FN_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        runCheck("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        runCheck("divu_big", FN_DIVU, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);

        // MFLO held behind a running DIV; an ADD slips through without stalling.
        applyStimulus(1'b1, FN_DIV, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b1, FN_ADD, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        checkOutput("add_no_stall", md_if.stall, 32'd0);
        checkOutput("add_busy", md_if.busy, 32'd1);
        repeat (3) applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
        stall_cycles = 0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!md_if.stall) begin
                found = 1'b1;
                break;
            end
            stall_cycles++;
        end
        checkOutput("mflo_stall_released", found, 32'd1);
        checkOutput("mflo_stall_cycles", stall_cycles, 32'd29);
        checkOutput("mflo_in_done_cycle", md_if.done, 32'd1);
        checkOutput("mflo_data", md_if.mf_data, 32'd14);
        checkOutput("div_rem_hi", md_if.hi, 32'd2);

        // Cancel while CALC is at iteration 10.
        applyStimulus(1'b1, FN_MULT, 32'd5, 32'd6, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        repeat (9) applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("cancel_idle", md_if.busy, 32'd0);
        checkOutput("cancel_hi_kept", md_if.hi, 32'd2);
        checkOutput("cancel_lo_kept", md_if.lo, 32'd14);
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_if.done) done_pulses++;
        end
        checkOutput("cancel_no_done", done_pulses, 32'd0);

        // Asynchronous reset in the middle of CALC, with MFHI presented.
        applyStimulus(1'b1, FN_MULTU, 32'h1234, 32'h5678, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        md_if.op_valid = 1'b1;
        md_if.funct    = FN_MFHI;
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_hi", md_if.hi, 32'd0);
        checkOutput("areset_lo", md_if.lo, 32'd0);
        checkOutput("areset_busy", md_if.busy, 32'd0);
        checkOutput("areset_stall", md_if.stall, 32'd0);
        checkOutput("areset_done", md_if.done, 32'd0);
        checkOutput("areset_mf_data", md_if.mf_data, 32'd0);
        #3 reset = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

        applyStimulus(1'b1, FN_MTHI, 32'h12345678, 32'd0, 1'b0);
        applyStimulus(1'b1, FN_MFHI, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mthi_mfhi", md_if.mf_data, 32'h12345678);
        checkOutput("mfhi_no_stall", md_if.stall, 32'd0);
        applyStimulus(1'b1, FN_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
        applyStimulus(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mtlo_mflo", md_if.mf_data, 32'hCAFEF00D);
        checkOutput("mtlo_hi_kept", md_if.hi, 32'h12345678);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

        // Second MULT issued in the done cycle of the first.
        applyStimulus(1'b1, FN_MULTU, 32'd7, 32'd9, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        waitDone("b2b_first", cyc);
        checkOutput("b2b_first_lo", md_if.lo, 32'd63);
        #1;
        md_if.op_valid = 1'b1;
        md_if.funct    = FN_MULT;
        md_if.a        = 32'h00010000;
        md_if.b        = 32'hFFFF0000;
        @(posedge clk);
        #1 md_if.op_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_no_gap", md_if.busy, 32'd1);
        waitDone("b2b_second", cyc);
        checkOutput("b2b_second_busy_cycles", cyc, 32'd32);
        checkOutput("b2b_second_hi", md_if.hi, 32'hFFFFFFFF);
        checkOutput("b2b_second_lo", md_if.lo, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
